// File: rtl/uart_core.sv
// Parametrised full-duplex UART: 16x-oversampled TX and RX with glitch reject,
// first-word-fall-through RX FIFO and sticky frame/parity/overrun flags.
module uart_core #(
  parameter int unsigned CLK_DIV       = 326,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned PARITY_EN     = 0,
  parameter int unsigned PARITY_ODD    = 0,
  parameter int unsigned STOP_BITS     = 1,
  parameter int unsigned RX_FIFO_DEPTH = 4
) (
  input  logic                           ex_clk,
  input  logic                           reset,
  input  logic                           rx_pin,
  output logic                           tx_pin,
  input  logic [DATA_BITS-1:0]           tx_data,
  input  logic                           tx_valid,
  output logic                           tx_ready,
  output logic [DATA_BITS-1:0]           rx_data,
  output logic                           rx_valid,
  input  logic                           rx_ready,
  output logic [$clog2(RX_FIFO_DEPTH):0] rx_count,
  output logic                           frame_err,
  output logic                           parity_err,
  output logic                           overrun,
  input  logic                           err_clear
);

  localparam int unsigned PW = $clog2(CLK_DIV);
  localparam int unsigned IW = $clog2(DATA_BITS);
  localparam int unsigned AW = $clog2(RX_FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(RX_FIFO_DEPTH);
  localparam logic          PAR_ODD   = 1'(PARITY_ODD != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- transmitter ----------------
  state_t                 tx_state, tx_state_n;
  logic [PW-1:0]          tx_presc, tx_presc_n;
  logic [3:0]             tx_tick, tx_tick_n;
  logic [IW-1:0]          tx_idx, tx_idx_n;
  logic [DATA_BITS-1:0]   tx_shift, tx_shift_n;
  logic                   tx_par, tx_par_n, tx_pin_n, tx_ready_n, tx_bit_end;

  always_ff @(posedge ex_clk or posedge reset) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_presc <= '0;
      tx_tick  <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_pin   <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_presc <= tx_presc_n;
      tx_tick  <= tx_tick_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
      tx_par   <= tx_par_n;
      tx_pin   <= tx_pin_n;
      tx_ready <= tx_ready_n;
    end
  end

  // Every wire transition happens on a bit boundary, so tx_pin stays a flop.
  always_comb begin
    tx_state_n = tx_state;
    tx_presc_n = tx_presc;
    tx_tick_n  = tx_tick;
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    tx_par_n   = tx_par;
    tx_pin_n   = tx_pin;
    tx_ready_n = tx_ready;
    tx_bit_end = (tx_presc == PRESC_MAX) && (tx_tick == 4'd15);
    if (tx_state != S_IDLE) begin
      tx_presc_n = (tx_presc == PRESC_MAX) ? '0 : tx_presc + 1'b1;
      if (tx_presc == PRESC_MAX) tx_tick_n = tx_tick + 4'd1;
    end
    case (tx_state)
      S_IDLE: if (tx_valid && tx_ready) begin
        tx_state_n = S_START;
        tx_shift_n = tx_data;
        tx_par_n   = (^tx_data) ^ PAR_ODD;
        tx_presc_n = '0;
        tx_tick_n  = '0;
        tx_pin_n   = 1'b0;
        tx_ready_n = 1'b0;
      end
      S_START: if (tx_bit_end) begin
        tx_state_n = S_DATA;
        tx_idx_n   = '0;
        tx_pin_n   = tx_shift[0];
        tx_shift_n = {1'b0, tx_shift[DATA_BITS-1:1]};
      end
      S_DATA: if (tx_bit_end) begin
        if (tx_idx == IDX_LAST) begin
          tx_idx_n = '0;
          if (PARITY_EN != 0) begin
            tx_state_n = S_PARITY;
            tx_pin_n   = tx_par;
          end else begin
            tx_state_n = S_STOP;
            tx_pin_n   = 1'b1;
          end
        end else begin
          tx_idx_n   = tx_idx + 1'b1;
          tx_pin_n   = tx_shift[0];
          tx_shift_n = {1'b0, tx_shift[DATA_BITS-1:1]};
        end
      end
      S_PARITY: if (tx_bit_end) begin
        tx_state_n = S_STOP;
        tx_pin_n   = 1'b1;
      end
      S_STOP: if (tx_bit_end) begin
        if (tx_idx == STOP_LAST) begin
          tx_state_n = S_IDLE;
          tx_ready_n = 1'b1;
        end else begin
          tx_idx_n = tx_idx + 1'b1;
        end
      end
      default: tx_state_n = S_IDLE;
    endcase
  end

  // ---------------- receiver ----------------
  logic [1:0]             rx_sync;
  logic                   rx_s, rx_prev;
  state_t                 rx_state, rx_state_n;
  logic [PW-1:0]          rx_presc, rx_presc_n;
  logic [3:0]             rx_tick, rx_tick_n;
  logic [IW-1:0]          rx_idx, rx_idx_n;
  logic [DATA_BITS-1:0]   rx_shift, rx_shift_n;
  logic                   rx_par_bad, rx_par_bad_n, rx_sample, rx_bit_end;
  logic                   push_c, pop_c, fifo_full, set_frame_c, set_par_c, set_ovr_c;

  assign rx_s = rx_sync[1];

  always_ff @(posedge ex_clk or posedge reset) begin
    if (reset) begin
      rx_sync    <= 2'b11;
      rx_prev    <= 1'b1;
      rx_state   <= S_IDLE;
      rx_presc   <= '0;
      rx_tick    <= '0;
      rx_idx     <= '0;
      rx_shift   <= '0;
      rx_par_bad <= 1'b0;
    end else begin
      rx_sync    <= {rx_sync[0], rx_pin};
      rx_prev    <= rx_s;
      rx_state   <= rx_state_n;
      rx_presc   <= rx_presc_n;
      rx_tick    <= rx_tick_n;
      rx_idx     <= rx_idx_n;
      rx_shift   <= rx_shift_n;
      rx_par_bad <= rx_par_bad_n;
    end
  end

  // Sampling on tick 8 lands mid-bit; the frame outcome is resolved at the first stop sample.
  always_comb begin
    rx_state_n   = rx_state;
    rx_presc_n   = rx_presc;
    rx_tick_n    = rx_tick;
    rx_idx_n     = rx_idx;
    rx_shift_n   = rx_shift;
    rx_par_bad_n = rx_par_bad;
    push_c       = 1'b0;
    set_frame_c  = 1'b0;
    set_par_c    = 1'b0;
    set_ovr_c    = 1'b0;
    rx_sample    = (rx_tick == 4'd8) && (rx_presc == '0);
    rx_bit_end   = (rx_presc == PRESC_MAX) && (rx_tick == 4'd15);
    if (rx_state != S_IDLE) begin
      rx_presc_n = (rx_presc == PRESC_MAX) ? '0 : rx_presc + 1'b1;
      if (rx_presc == PRESC_MAX) rx_tick_n = rx_tick + 4'd1;
    end
    case (rx_state)
      S_IDLE: if (rx_prev && !rx_s) begin
        rx_state_n   = S_START;
        rx_presc_n   = '0;
        rx_tick_n    = '0;
        rx_par_bad_n = 1'b0;
      end
      S_START: begin
        if (rx_sample && rx_s) rx_state_n = S_IDLE;
        else if (rx_bit_end) begin
          rx_state_n = S_DATA;
          rx_idx_n   = '0;
        end
      end
      S_DATA: begin
        if (rx_sample) rx_shift_n = {rx_s, rx_shift[DATA_BITS-1:1]};
        if (rx_bit_end) begin
          if (rx_idx == IDX_LAST) rx_state_n = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          else rx_idx_n = rx_idx + 1'b1;
        end
      end
      S_PARITY: begin
        if (rx_sample) rx_par_bad_n = ((^rx_shift) ^ PAR_ODD) != rx_s;
        if (rx_bit_end) rx_state_n = S_STOP;
      end
      S_STOP: if (rx_sample) begin
        rx_state_n = S_IDLE;
        if (!rx_s)                   set_frame_c = 1'b1;
        else if (rx_par_bad)         set_par_c   = 1'b1;
        else if (fifo_full && !pop_c) set_ovr_c  = 1'b1;
        else                         push_c      = 1'b1;
      end
      default: rx_state_n = S_IDLE;
    endcase
  end

  // ---------------- RX FIFO and flags ----------------
  logic [DATA_BITS-1:0] mem [RX_FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count_n;

  assign fifo_full = (rx_count == DEPTH_C);
  assign pop_c     = rx_valid && rx_ready;
  assign count_n   = rx_count + CW'(push_c) - CW'(pop_c);
  assign rx_data   = mem[rd_ptr];

  always_ff @(posedge ex_clk) begin
    if (push_c) mem[wr_ptr] <= rx_shift;
  end

  always_ff @(posedge ex_clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rx_count   <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + 1'b1;
      if (pop_c)  rd_ptr <= rd_ptr + 1'b1;
      rx_count   <= count_n;
      rx_valid   <= (count_n != '0);
      frame_err  <= set_frame_c | (frame_err  & ~err_clear);
      parity_err <= set_par_c   | (parity_err & ~err_clear);
      overrun    <= set_ovr_c   | (overrun    & ~err_clear);
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Directed scoreboard bench for uart_core: CLK_DIV=4, 8 data bits, odd parity,
// 2 stop bits, 4-entry RX FIFO; TX wire checks, loopback, glitch, errors, overrun, reset.
module tb_uart_core;

  localparam int BIT  = 64;
  localparam int LAT  = 12 * BIT;

  logic       ex_clk = 1'b0;
  logic       reset, rx_pin, tx_pin, tx_valid, tx_ready, rx_valid, rx_ready;
  logic       frame_err, parity_err, overrun, err_clear, loopback, drv_rx;
  logic [7:0] tx_data, rx_data;
  logic [2:0] rx_count;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic       fe_seen;

  always #5 ex_clk = ~ex_clk;
  assign rx_pin = loopback ? tx_pin : drv_rx;

  uart_core #(
    .CLK_DIV(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1),
    .STOP_BITS(2), .RX_FIFO_DEPTH(4)
  ) dut (
    .ex_clk(ex_clk), .reset(reset), .rx_pin(rx_pin), .tx_pin(tx_pin),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_count(rx_count), .frame_err(frame_err), .parity_err(parity_err),
    .overrun(overrun), .err_clear(err_clear)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ex_clk); #1;
  endtask

  // Send one byte, checking every bit mid-period on the wire and the tx_ready latency.
  task automatic send(input logic [7:0] d, input bit expect_rx);
    logic [11:0] exp_bits;
    int n;
    exp_bits = {2'b11, ~^d, d, 1'b0};
    n = 0;
    while (!tx_ready && n < 2000) begin tick(); n++; end
    check("tx_ready_wait", 32'(tx_ready), 1);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tx_data  = ~d;
    if (expect_rx) exp_q.push_back(d);
    for (int c = 0; c <= LAT; c++) begin
      if (c == 0) check($sformatf("tx_ready_low_%02h", d), 32'(tx_ready), 0);
      if (c % BIT == BIT / 2)
        check($sformatf("tx_bit%0d_%02h", c / BIT, d), 32'(tx_pin), 32'(exp_bits[c / BIT]));
      if (c == LAT - 1) check($sformatf("tx_busy_end_%02h", d), 32'(tx_ready), 0);
      if (c == LAT) check($sformatf("tx_ready_back_%02h", d), 32'(tx_ready), 1);
      if (c < LAT) tick();
    end
  endtask

  task automatic pop_one(input string tag);
    int n;
    n = 0;
    while (!rx_valid && n < 2000) begin tick(); n++; end
    check({tag, "_valid"}, 32'(rx_valid), 1);
    check(tag, 32'(rx_data), 32'(exp_q.pop_front()));
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  // Drive a frame on rx_pin: start, 8 data LSB first, odd parity (optionally flipped), one stop.
  // pop_at_push pulses rx_ready on the cycle the first stop bit is sampled: two synchroniser
  // flops plus the edge-detect flop put the start at +3, and mid-stop is +10.5 bits after that.
  task automatic drive_frame(input logic [7:0] d, input logic par_flip,
                             input logic stop_val, input bit pop_at_push);
    logic [10:0] bits;
    bits = {stop_val, (~^d) ^ par_flip, d, 1'b0};
    for (int b = 0; b < 11; b++) begin
      drv_rx = bits[b];
      for (int c = 0; c < BIT; c++) begin
        if (pop_at_push && b == 10 && c == 35) begin
          check("pop_at_push_head", 32'(rx_data), 32'(exp_q.pop_front()));
          rx_ready = 1'b1;
        end
        tick();
        if (pop_at_push && b == 10 && c == 35) rx_ready = 1'b0;
      end
    end
    drv_rx = 1'b1;
    repeat (BIT) tick();
  endtask

  task automatic clear_flags();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
    err_clear = 1'b0; loopback = 1'b0; drv_rx = 1'b1;
    repeat (3) tick();
    check("rst_tx_pin", 32'(tx_pin), 1);
    check("rst_tx_ready", 32'(tx_ready), 1);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_count", 32'(rx_count), 0);
    check("rst_flags", {29'd0, frame_err, parity_err, overrun}, 0);
    reset = 1'b0;
    tick();

    // TX waveform of 0xA5, looped back into RX
    loopback = 1'b1;
    send(8'hA5, 1'b1);
    pop_one("rx_a5");

    // Back-to-back loopback frames
    send(8'h3C, 1'b1);
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    pop_one("rx_3c");
    pop_one("rx_00");
    pop_one("rx_ff");
    tick();
    check("loop_empty", 32'(rx_count), 0);
    check("loop_flags", {29'd0, frame_err, parity_err, overrun}, 0);

    // 20-cycle glitch on idle line
    loopback = 1'b0;
    drv_rx = 1'b0;
    repeat (20) tick();
    drv_rx = 1'b1;
    repeat (300) tick();
    check("glitch_rx_valid", 32'(rx_valid), 0);
    check("glitch_flags", {29'd0, frame_err, parity_err, overrun}, 0);

    // Bad stop bit
    drive_frame(8'h55, 1'b0, 1'b0, 1'b0);
    check("badstop_frame_err", 32'(frame_err), 1);
    check("badstop_rx_valid", 32'(rx_valid), 0);
    clear_flags();
    check("badstop_cleared", 32'(frame_err), 0);

    // err_clear held while a bad-stop frame completes: the set must win
    fe_seen = 1'b0;
    err_clear = 1'b1;
    fork
      drive_frame(8'h55, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 12 * BIT; c++) begin
        @(negedge ex_clk);
        if (frame_err) fe_seen = 1'b1;
      end
    join
    err_clear = 1'b0;
    check("set_beats_clear", 32'(fe_seen), 1);
    check("held_clear_rx_valid", 32'(rx_valid), 0);

    // Bad parity
    drive_frame(8'h33, 1'b1, 1'b1, 1'b0);
    check("badpar_parity_err", 32'(parity_err), 1);
    check("badpar_frame_err", 32'(frame_err), 0);
    check("badpar_rx_valid", 32'(rx_valid), 0);
    clear_flags();
    check("badpar_cleared", 32'(parity_err), 0);

    // Overrun: five bytes into a four-deep FIFO with no pops
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      drive_frame(8'(i), 1'b0, 1'b1, 1'b0);
    end
    check("ovr_count", 32'(rx_count), 4);
    check("ovr_flag", 32'(overrun), 1);
    for (int i = 1; i <= 4; i++) pop_one($sformatf("ovr_pop%0d", i));
    check("ovr_drained", 32'(rx_count), 0);
    clear_flags();
    check("ovr_cleared", 32'(overrun), 0);

    // Same again, popping on the fifth push cycle
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i));
      drive_frame(8'(i), 1'b0, 1'b1, 1'b0);
    end
    drive_frame(8'h05, 1'b0, 1'b1, 1'b1);
    exp_q.push_back(8'h05);
    check("pushpop_count", 32'(rx_count), 4);
    check("pushpop_no_ovr", 32'(overrun), 0);
    for (int i = 2; i <= 5; i++) pop_one($sformatf("pushpop_pop%0d", i));

    // Reset during TX data bit 2 while RX is mid-frame via loopback
    loopback = 1'b1;
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (3 * BIT + 20) tick();
    check("pre_reset_tx_pin", 32'(tx_pin), 0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_tx_pin", 32'(tx_pin), 1);
    check("async_rst_tx_ready", 32'(tx_ready), 1);
    tick();
    tick();
    reset = 1'b0;
    repeat (1000) tick();
    check("post_rst_no_partial", 32'(rx_valid), 0);
    check("post_rst_count", 32'(rx_count), 0);
    send(8'h96, 1'b1);
    pop_one("post_rst_rx_96");
    check("post_rst_flags", {29'd0, frame_err, parity_err, overrun}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1);
  end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Parametrised full-duplex UART, next generation of the fixed 8N1/9600 block.
- Configurable divisor, data width, parity and stop bits; 16x oversampled receiver with glitch reject; valid/ready TX handshake; RX FIFO; sticky error flags.
- Sits between the SD host controller's register interface and the board serial pins.

Parameters:
- CLK_DIV, 326: ex_clk cycles per oversample tick; baud = f_ex_clk/(16*CLK_DIV); 326 gives 9585 bps at 50 MHz. Must be ≥2.
- DATA_BITS, 8: data bits per frame, 5..9.
- PARITY_EN, 0: 1 inserts/checks a parity bit.
- PARITY_ODD, 0: 1 selects odd parity, 0 selects even. Ignored if PARITY_EN=0.
- STOP_BITS, 1: TX stop bits, 1 or 2.
- RX_FIFO_DEPTH, 4: RX FIFO entries, power of two, ≥2.

Ports:
- ex_clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_pin  in  1  serial input, idle high, asynchronous to ex_clk
- tx_pin  out  1  serial output, idle high
- tx_data  in  DATA_BITS  byte to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  transmitter can accept
- rx_data  out  DATA_BITS  FIFO head
- rx_valid  out  1  FIFO non-empty
- rx_ready  in  1  pop FIFO head
- rx_count  out  $clog2(RX_FIFO_DEPTH)+1  FIFO occupancy
- frame_err  out  1  sticky: stop bit sampled low
- parity_err  out  1  sticky: parity mismatch
- overrun  out  1  sticky: byte dropped, FIFO full
- err_clear  in  1  clears all three sticky flags

Behaviour:
- Reset, asynchronous: tx_pin=1, tx_ready=1, FIFO empty, rx_valid=0, rx_count=0, all flags 0, RX synchroniser flops=1, both FSMs IDLE, prescalers 0.
- Reset mid-frame aborts the frame. tx_pin goes high immediately and the partial RX byte is discarded.
- Tick and bit timing:
  - TX and RX each own a prescaler (0..CLK_DIV-1) and a 4-bit tick counter.
  - One bit = exactly 16*CLK_DIV ex_clk cycles.
  - TX counters reset on accept; RX counters reset on start-edge detection.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - Accept when tx_valid && tx_ready in IDLE. Latch tx_data. The next cycle has tx_ready=0 and tx_pin=0.
  - Data bits go out LSB first.
  - Parity bit = XOR of the data bits for even parity, inverted for odd.
  - STOP drives 1 for STOP_BITS bit periods.
  - tx_ready returns to 1 on the first cycle after the final stop period.
  - Accept-to-tx_ready latency = 16*CLK_DIV*(1+DATA_BITS+PARITY_EN+STOP_BITS) cycles.
  - tx_data changes while tx_ready=0 are ignored.
- RX synchroniser and detection: 2-flop synchroniser. In IDLE, a synchronised 1→0 transition enters START.
- RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - All sampling happens on tick 8 of each bit (mid-bit).
  - START sampled high: glitch. Return to IDLE, no flags, nothing pushed.
  - Data bits are assembled LSB first.
  - Parity is checked when PARITY_EN=1.
  - Only the first stop bit is checked. The FSM returns to IDLE right after the stop sample, so it can resync on a following start bit.
- RX frame outcome, evaluated in this priority:
  1. Stop bit low: set frame_err, discard the byte.
  2. Parity mismatch: set parity_err, discard the byte.
  3. FIFO full with no simultaneous pop: set overrun, drop the byte; FIFO contents unchanged.
  4. Otherwise push the byte.
- FIFO:
  - First-word-fall-through: rx_data is the head whenever rx_valid=1. rx_data is don't-care when empty.
  - Pop on rx_valid && rx_ready. rx_ready while empty has no effect.
  - Simultaneous push and pop while full: both happen, no overrun, count unchanged.
  - Pointers wrap modulo RX_FIFO_DEPTH. rx_count counts 0..RX_FIFO_DEPTH.
- Flags: err_clear clears all three next cycle. If a set event and err_clear hit the same cycle, set wins.
- TX and RX are fully independent; loopback tx_pin→rx_pin must work.

Test Plan:
- CLK_DIV=4, 8N1: tx 0xA5 -> tx_pin low 64 cycles, then 1,0,1,0,0,1,0,1 at 64 cycles each, then high. tx_ready=1 again 640 cycles after accept.
- Loopback, CLK_DIV=4, PARITY_EN=1, PARITY_ODD=1, STOP_BITS=2, send 0x3C, 0x00, 0xFF back to back -> each frame on the wire is 12 bits. Parity bits 1,1,1. FIFO delivers the three bytes in order with no flags.
- Inject a 20-cycle low pulse on idle rx_pin -> no push, no flags, rx_valid stays 0.
- Drive frame 0x55 with stop bit low -> frame_err=1 and FIFO stays empty. Then err_clear -> frame_err=0. Then err_clear held while a bad-stop frame completes -> frame_err=1 on that cycle.
- RX_FIFO_DEPTH=4, receive 5 bytes 0x01..0x05 without popping -> rx_count=4, overrun=1, pops return 0x01..0x04. Repeat with rx_ready pulsed on the 5th push cycle -> overrun=0, rx_count=4.
- Assert reset at bit 3 of a TX frame and mid-way through an RX frame -> tx_pin=1 and tx_ready=1 immediately. No partial byte appears. The next frame transmits and receives correctly.
